// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared definitions for the junction phase scheduler: lamp codes, phase codes,
// FSM state encoding and the phase -> lamp-group mask used by the lamp decoder.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [1:0] PH_P0   = 2'd0;
    localparam logic [1:0] PH_P1   = 2'd1;
    localparam logic [1:0] PH_P2   = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    localparam logic [1:0] ST_GREEN   = 2'd0;
    localparam logic [1:0] ST_YELLOW  = 2'd1;
    localparam logic [1:0] ST_ALL_RED = 2'd2;

    // Mask bit order is {M1, M2, MT, S}; a set bit means that lamp is green in the phase.
    function automatic logic [3:0] lamp_mask(input logic [1:0] ph);
        logic [3:0] m;
        case (ph)
            PH_P0:   m = 4'b1100;
            PH_P1:   m = 4'b1010;
            PH_P2:   m = 4'b0001;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] lamp_code(input logic grn, input logic yel);
        logic [2:0] c;
        if (grn) begin
            c = LAMP_GRN;
        end else if (yel) begin
            c = LAMP_YEL;
        end else begin
            c = LAMP_RED;
        end
        return c;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// State-dwell timer: clears on request, otherwise counts up and saturates at all-ones.
// The next-count value is exported so the owner can register outputs in step with it.
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic [TW-1:0] count,
    output logic [TW-1:0] count_nxt
);

    // Next count: clear, hold at saturation, or increment.
    always_comb begin
        if (clr) begin
            count_nxt = {TW{1'b0}};
        end else if (count == {TW{1'b1}}) begin
            count_nxt = count;
        end else begin
            count_nxt = count + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= {TW{1'b0}};
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Junction phase sequencer: arbitrates vehicle/pedestrian/emergency requests between
// three phases, sequences GREEN -> YELLOW -> ALL_RED and drives registered lamp codes.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TW           = 8,
    parameter int MIN_GREEN    = 10,
    parameter int MAX_GREEN    = 60,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int WALK_TIME    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_s,
    input  logic       req_mt,
    input  logic       ped_req,
    input  logic       emerg_req,
    input  logic [1:0] emerg_phase,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic       ped_walk,
    output logic [1:0] cur_phase
);

    localparam logic [TW-1:0] MIN_LIM  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LIM  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LIM  = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] AR_LIM   = TW'(ALL_RED_TIME - 1);
    localparam logic [TW-1:0] WALK_LIM = TW'(WALK_TIME);

    logic [1:0]    state_r, cur_r, next_r;
    logic [1:0]    state_nxt_s, cur_nxt_s, next_nxt_s, rr_next_s;
    logic          pend_side_r, pend_mt_r, ped_pend_r, walk_en_r;
    logic          pend_side_nxt_s, pend_mt_nxt_s, ped_pend_nxt_s, walk_en_nxt_s;
    logic          emerg_act_s, demand_s, other_pend_s, green_exit_s, enter_green_s;
    logic          tmr_clr_s, walk_nxt_s;
    logic [TW-1:0] tmr_s, tmr_nxt_s;
    logic [3:0]    keep_s, grn_s, yel_s;

    phase_timer #(.TW(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (tmr_clr_s),
        .count     (tmr_s),
        .count_nxt (tmr_nxt_s)
    );

    // Arbitration: demand for the current phase, pending elsewhere, round-robin successor.
    always_comb begin
        emerg_act_s = emerg_req && (emerg_phase != PH_NONE);
        case (cur_r)
            PH_P0: begin
                demand_s  = 1'b1;
                rr_next_s = pend_mt_r ? PH_P1 : PH_P2;
            end
            PH_P1: begin
                demand_s  = req_mt;
                rr_next_s = pend_side_r ? PH_P2 : PH_P0;
            end
            default: begin
                demand_s  = req_s;
                rr_next_s = PH_P0;
            end
        endcase
        // P0 is implicitly always waiting whenever it does not own the junction.
        other_pend_s = (cur_r != PH_P0) || ((cur_r != PH_P1) && pend_mt_r)
                       || ((cur_r != PH_P2) && pend_side_r);
        green_exit_s = (tmr_s >= MIN_LIM) && other_pend_s && ((tmr_s >= MAX_LIM) || !demand_s);
    end

    // Phase FSM next-state; an emergency for the running phase freezes it in GREEN.
    always_comb begin
        state_nxt_s = state_r;
        cur_nxt_s   = cur_r;
        next_nxt_s  = next_r;
        case (state_r)
            ST_GREEN: begin
                if (emerg_act_s && (emerg_phase != cur_r)) begin
                    state_nxt_s = ST_YELLOW;
                    next_nxt_s  = emerg_phase;
                end else if (!emerg_act_s && green_exit_s) begin
                    state_nxt_s = ST_YELLOW;
                    next_nxt_s  = rr_next_s;
                end else begin
                    state_nxt_s = ST_GREEN;
                end
            end
            ST_YELLOW: begin
                if (tmr_s >= YEL_LIM) begin
                    state_nxt_s = ST_ALL_RED;
                end else begin
                    state_nxt_s = ST_YELLOW;
                end
            end
            ST_ALL_RED: begin
                if (tmr_s >= AR_LIM) begin
                    state_nxt_s = ST_GREEN;
                    cur_nxt_s   = next_r;
                end else begin
                    state_nxt_s = ST_ALL_RED;
                end
            end
            default: begin
                state_nxt_s = ST_ALL_RED;
                cur_nxt_s   = PH_P0;
                next_nxt_s  = PH_P0;
            end
        endcase
        tmr_clr_s     = (state_nxt_s != state_r);
        enter_green_s = (state_r != ST_GREEN) && (state_nxt_s == ST_GREEN);
    end

    // Sticky request latches; a new request in the clearing cycle survives the clear.
    always_comb begin
        pend_side_nxt_s = req_s | ped_req
                          | (pend_side_r & ~(enter_green_s & (cur_nxt_s == PH_P2)));
        pend_mt_nxt_s   = req_mt | (pend_mt_r & ~(enter_green_s & (cur_nxt_s == PH_P1)));
        ped_pend_nxt_s  = ped_req | (ped_pend_r & ~(enter_green_s & (cur_nxt_s == PH_P2)));
        if (enter_green_s && (cur_nxt_s == PH_P2)) begin
            walk_en_nxt_s = ped_pend_r;
        end else begin
            walk_en_nxt_s = walk_en_r;
        end
    end

    // Lamp decode from next state; lamps green in both outgoing and incoming phases keep green.
    always_comb begin
        if (cur_nxt_s != next_nxt_s) begin
            keep_s = lamp_mask(cur_nxt_s) & lamp_mask(next_nxt_s);
        end else begin
            keep_s = 4'b0000;
        end
        case (state_nxt_s)
            ST_GREEN: begin
                grn_s = lamp_mask(cur_nxt_s);
                yel_s = 4'b0000;
            end
            ST_YELLOW: begin
                grn_s = keep_s;
                yel_s = lamp_mask(cur_nxt_s) & ~keep_s;
            end
            default: begin
                grn_s = keep_s;
                yel_s = 4'b0000;
            end
        endcase
        walk_nxt_s = (state_nxt_s == ST_GREEN) && (cur_nxt_s == PH_P2)
                     && walk_en_nxt_s && (tmr_nxt_s < WALK_LIM);
    end

    // State, pending and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_ALL_RED;
            cur_r       <= PH_P0;
            next_r      <= PH_P0;
            pend_side_r <= 1'b0;
            pend_mt_r   <= 1'b0;
            ped_pend_r  <= 1'b0;
            walk_en_r   <= 1'b0;
            light_M1    <= LAMP_RED;
            light_M2    <= LAMP_RED;
            light_MT    <= LAMP_RED;
            light_S     <= LAMP_RED;
            ped_walk    <= 1'b0;
            cur_phase   <= PH_P0;
        end else begin
            state_r     <= state_nxt_s;
            cur_r       <= cur_nxt_s;
            next_r      <= next_nxt_s;
            pend_side_r <= pend_side_nxt_s;
            pend_mt_r   <= pend_mt_nxt_s;
            ped_pend_r  <= ped_pend_nxt_s;
            walk_en_r   <= walk_en_nxt_s;
            light_M1    <= lamp_code(grn_s[3], yel_s[3]);
            light_M2    <= lamp_code(grn_s[2], yel_s[2]);
            light_MT    <= lamp_code(grn_s[1], yel_s[1]);
            light_S     <= lamp_code(grn_s[0], yel_s[0]);
            ped_walk    <= walk_nxt_s;
            cur_phase   <= cur_nxt_s;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: directed segments push hand-computed
// per-cycle expectations; a negedge monitor pops and compares the DUT outputs.
module tb_traffic_phase_scheduler;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    // Input vector {rst, req_s, req_mt, ped_req, emerg_req, emerg_phase[1:0]}
    localparam logic [6:0] I_IDLE = 7'b1000011;
    localparam logic [6:0] I_RST  = 7'b0000011;
    localparam logic [6:0] I_S    = 7'b1100011;
    localparam logic [6:0] I_MT   = 7'b1010011;
    localparam logic [6:0] I_SMT  = 7'b1110011;
    localparam logic [6:0] I_PED  = 7'b1001011;
    localparam logic [6:0] I_EM2  = 7'b1000110;

    typedef struct {
        string      nm;
        logic [2:0] m1, m2, mt, s;
        logic       w;
        logic [1:0] ph;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, req_s, req_mt, ped_req, emerg_req;
    logic [1:0] emerg_phase;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       ped_walk;
    logic [1:0] cur_phase;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    traffic_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_s       (req_s),
        .req_mt      (req_mt),
        .ped_req     (ped_req),
        .emerg_req   (emerg_req),
        .emerg_phase (emerg_phase),
        .light_M1    (light_M1),
        .light_M2    (light_M2),
        .light_MT    (light_MT),
        .light_S     (light_S),
        .ped_walk    (ped_walk),
        .cur_phase   (cur_phase)
    );

    always #5 clk = ~clk;

    // Each entry describes the outputs visible during the cycle its inputs are applied.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if ({light_M1, light_M2, light_MT, light_S, ped_walk, cur_phase} !==
                {mon_e.m1, mon_e.m2, mon_e.mt, mon_e.s, mon_e.w, mon_e.ph}) begin
                n_bad++;
                $display("FAIL %s @%0t: got M1=%b M2=%b MT=%b S=%b walk=%b ph=%0d, need M1=%b M2=%b MT=%b S=%b walk=%b ph=%0d",
                         mon_e.nm, $time, light_M1, light_M2, light_MT, light_S, ped_walk, cur_phase,
                         mon_e.m1, mon_e.m2, mon_e.mt, mon_e.s, mon_e.w, mon_e.ph);
            end
        end
    end

    task automatic seg(input int n, input logic [6:0] in,
                       input logic [2:0] m1, input logic [2:0] m2,
                       input logic [2:0] mt, input logic [2:0] s,
                       input logic w, input logic [1:0] ph, input string nm);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            {rst, req_s, req_mt, ped_req, emerg_req, emerg_phase} = in;
            e.nm = nm; e.m1 = m1; e.m2 = m2; e.mt = mt; e.s = s; e.w = w; e.ph = ph;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    // Reset held two cycles, then ALL_RED (tmr 0 and 1) before P0 green.
    task automatic do_reset();
        seg(2, I_RST,  R, R, R, R, 1'b0, 2'd0, "reset_low");
        seg(2, I_IDLE, R, R, R, R, 1'b0, 2'd0, "release_red");
    endtask

    initial begin
        {rst, req_s, req_mt, ped_req, emerg_req, emerg_phase} = I_RST;
        @(posedge clk);
        #1;

        // Side-street pulse: P0 runs to MAX_GREEN, S gets MIN_GREEN, back to P0.
        do_reset();
        seg(1,  I_S,    G, G, R, R, 1'b0, 2'd0, "p0_green_req_s");
        seg(59, I_IDLE, G, G, R, R, 1'b0, 2'd0, "p0_green");
        seg(3,  I_IDLE, Y, Y, R, R, 1'b0, 2'd0, "p0_yellow");
        seg(2,  I_IDLE, R, R, R, R, 1'b0, 2'd0, "p0_allred");
        seg(10, I_IDLE, R, R, R, G, 1'b0, 2'd2, "s_green_min");
        seg(3,  I_IDLE, R, R, R, Y, 1'b0, 2'd2, "s_yellow");
        seg(2,  I_IDLE, R, R, R, R, 1'b0, 2'd2, "s_allred");
        seg(5,  I_IDLE, G, G, R, R, 1'b0, 2'd0, "p0_hold_idle");

        // Both sensors held: round-robin 0,1,2,0 with M1 continuing into P1.
        do_reset();
        seg(60, I_SMT, G, G, R, R, 1'b0, 2'd0, "rr_p0_green");
        seg(3,  I_SMT, G, Y, R, R, 1'b0, 2'd0, "rr_p0_yellow");
        seg(2,  I_SMT, G, R, R, R, 1'b0, 2'd0, "rr_p0_allred");
        seg(60, I_SMT, G, R, G, R, 1'b0, 2'd1, "rr_p1_green");
        seg(3,  I_SMT, Y, R, Y, R, 1'b0, 2'd1, "rr_p1_yellow");
        seg(2,  I_SMT, R, R, R, R, 1'b0, 2'd1, "rr_p1_allred");
        seg(60, I_SMT, R, R, R, G, 1'b0, 2'd2, "rr_p2_green");
        seg(3,  I_SMT, R, R, R, Y, 1'b0, 2'd2, "rr_p2_yellow");
        seg(2,  I_SMT, R, R, R, R, 1'b0, 2'd2, "rr_p2_allred");
        seg(1,  I_SMT, G, G, R, R, 1'b0, 2'd0, "rr_p0_again");

        // Pedestrian pulse: walk lamp on for the first WALK_TIME cycles of S green.
        do_reset();
        seg(1,  I_PED,  G, G, R, R, 1'b0, 2'd0, "ped_p0_green");
        seg(59, I_IDLE, G, G, R, R, 1'b0, 2'd0, "ped_p0_green");
        seg(3,  I_IDLE, Y, Y, R, R, 1'b0, 2'd0, "ped_p0_yellow");
        seg(2,  I_IDLE, R, R, R, R, 1'b0, 2'd0, "ped_p0_allred");
        seg(7,  I_IDLE, R, R, R, G, 1'b1, 2'd2, "ped_walk_on");
        seg(3,  I_IDLE, R, R, R, G, 1'b0, 2'd2, "ped_walk_off");
        seg(3,  I_IDLE, R, R, R, Y, 1'b0, 2'd2, "ped_s_yellow");
        seg(2,  I_IDLE, R, R, R, R, 1'b0, 2'd2, "ped_s_allred");
        seg(1,  I_IDLE, G, G, R, R, 1'b0, 2'd0, "ped_p0_return");

        // Emergency for S at P0 tmr=3: immediate yellow, S held past MAX_GREEN.
        do_reset();
        seg(3,   I_IDLE, G, G, R, R, 1'b0, 2'd0, "em_p0_green");
        seg(1,   I_EM2,  G, G, R, R, 1'b0, 2'd0, "em_p0_tmr3");
        seg(3,   I_EM2,  Y, Y, R, R, 1'b0, 2'd0, "em_yellow");
        seg(2,   I_EM2,  R, R, R, R, 1'b0, 2'd0, "em_allred");
        seg(120, I_EM2,  R, R, R, G, 1'b0, 2'd2, "em_s_hold");
        seg(1,   I_IDLE, R, R, R, G, 1'b0, 2'd2, "em_drop");
        seg(3,   I_IDLE, R, R, R, Y, 1'b0, 2'd2, "em_s_yellow");
        seg(2,   I_IDLE, R, R, R, R, 1'b0, 2'd2, "em_s_allred");
        seg(1,   I_IDLE, G, G, R, R, 1'b0, 2'd0, "em_p0_return");

        // Reset in the middle of P0->P1 yellow discards the turn request.
        do_reset();
        seg(1,  I_MT,   G, G, R, R, 1'b0, 2'd0, "mt_p0_green");
        seg(59, I_IDLE, G, G, R, R, 1'b0, 2'd0, "mt_p0_green");
        seg(1,  I_IDLE, G, Y, R, R, 1'b0, 2'd0, "mt_yellow");
        seg(2,  I_RST,  R, R, R, R, 1'b0, 2'd0, "rst_mid_yellow");
        seg(2,  I_IDLE, R, R, R, R, 1'b0, 2'd0, "rst_release_red");
        seg(70, I_IDLE, G, G, R, R, 1'b0, 2'd0, "p0_no_mt");

        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
